// File: rtl/prog_loader_ram.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader_ram
// Description : 256x8 program/data RAM with a framed byte-stream loader.
//               Frame: SYNC_BYTE, start address, length (0 = 256), data
//               bytes[, checksum]. The CPU is held in reset and disabled
//               while a frame is loaded. It is then released so that it
//               fetches from the start address. The release happens on the
//               next rising edge of its slave clock, clk_in.
// Ports       : clk_qzt      - system clock, all logic on posedge
//               reset        - synchronous, active-high
//               clk_in       - CPU slave clock, edge-detected on clk_qzt
//               rx_data/rx_valid/rx_ready - host byte stream
//               cpu_addr/cpu_wdata/cpu_we - CPU memory port (data_addr,
//                              data_out, write_en)
//               cpu_rdata    - RAM read data, 1 cycle latency
//               cpu_en/cpu_reset/cpu_res_addr - CPU control
//               busy         - high unless the CPU is running
//               load_done    - one-cycle pulse on entering RUN
//               err          - sticky checksum error
// Options     : LOADER_CHECKSUM_EN adds the checksum byte, the CHK and
//               ERROR states, and a live err output. When it is undefined,
//               err is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader_ram #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         MEM_DEPTH = 256
) (
    input  logic       clk_qzt,
    input  logic       reset,
    input  logic       clk_in,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    input  logic       cpu_we,
    output logic [7:0] cpu_rdata,
    output logic       cpu_en,
    output logic       cpu_reset,
    output logic [7:0] cpu_res_addr,
    output logic       busy,
    output logic       load_done,
    output logic       err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ADDR    = 3'd1;
    localparam logic [2:0] S_LEN     = 3'd2;
    localparam logic [2:0] S_DATA    = 3'd3;
    localparam logic [2:0] S_CHK     = 3'd4;
    localparam logic [2:0] S_RELEASE = 3'd5;
    localparam logic [2:0] S_RUN     = 3'd6;
    localparam logic [2:0] S_ERROR   = 3'd7;

    logic [7:0] r_mem [0:MEM_DEPTH-1];

    logic [2:0] r_state;
    logic [2:0] w_next;
    logic [7:0] r_start;
    logic [7:0] r_ptr;
    logic [7:0] r_cnt;
    logic       r_clk_in_prev;
    logic       r_load_done;
    logic [7:0] r_cpu_rdata;

    logic       w_rx_ready;
    logic       w_cpu_en;
    logic       w_cpu_reset;
    logic       w_busy;
    logic       w_ld_we;
    logic       w_accept;
    logic       w_is_sync;
    logic       w_clk_rise;
    logic       w_mem_we;
    logic [7:0] w_mem_addr;
    logic [7:0] w_mem_wdata;

    assign w_accept   = rx_valid & w_rx_ready;
    assign w_is_sync  = (rx_data == SYNC_BYTE);
    assign w_clk_rise = clk_in & ~r_clk_in_prev;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] r_sum;
    logic       r_err;
    logic [7:0] w_chk_sum;
    assign w_chk_sum = r_sum + rx_data;
`endif

    // ------------------------------------------------------------------------
    // Next state and Moore-style control outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_next      = r_state;
        w_rx_ready  = 1'b1;
        w_cpu_en    = 1'b0;
        w_cpu_reset = 1'b1;
        w_busy      = 1'b1;
        w_ld_we     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_is_sync) w_next = S_ADDR;
            end
            S_ADDR: begin
                if (w_accept) w_next = S_LEN;
            end
            S_LEN: begin
                if (w_accept) w_next = S_DATA;
            end
            S_DATA: begin
                if (w_accept) begin
                    w_ld_we = 1'b1;
                    // A length of 0 wraps through 255..1 and yields 256 bytes.
                    if (r_cnt == 8'd1) begin
`ifdef LOADER_CHECKSUM_EN
                        w_next = S_CHK;
`else
                        w_next = S_RELEASE;
`endif
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                if (w_accept) w_next = (w_chk_sum == 8'h00) ? S_RELEASE : S_ERROR;
            end
            S_ERROR: begin
                if (w_accept && w_is_sync) w_next = S_ADDR;
            end
`endif
            S_RELEASE: begin
                w_rx_ready = 1'b0;
                w_cpu_en   = 1'b1;
                if (w_clk_rise) w_next = S_RUN;
            end
            S_RUN: begin
                w_cpu_en    = 1'b1;
                w_cpu_reset = 1'b0;
                w_busy      = 1'b0;
                if (w_accept && w_is_sync) w_next = S_ADDR;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Loader registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_qzt) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_start       <= 8'h00;
            r_ptr         <= 8'h00;
            r_cnt         <= 8'h00;
            r_clk_in_prev <= 1'b0;
            r_load_done   <= 1'b0;
            r_cpu_rdata   <= 8'h00;
        end else begin
            r_state       <= w_next;
            r_clk_in_prev <= clk_in;
            r_load_done   <= (r_state == S_RELEASE) && w_clk_rise;
            r_cpu_rdata   <= r_mem[cpu_addr];
            if (w_accept) begin
                case (r_state)
                    S_ADDR: begin
                        r_start <= rx_data;
                        r_ptr   <= rx_data;
                    end
                    S_LEN:  r_cnt <= rx_data;
                    S_DATA: begin
                        r_ptr <= r_ptr + 8'd1;
                        r_cnt <= r_cnt - 8'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running sum covers ADDR, LEN and data; CHK adds the checksum byte.
    always_ff @(posedge clk_qzt) begin
        if (reset) begin
            r_sum <= 8'h00;
            r_err <= 1'b0;
        end else begin
            if (w_accept) begin
                if (r_state == S_ADDR) begin
                    r_sum <= rx_data;
                end else if (r_state == S_LEN || r_state == S_DATA) begin
                    r_sum <= w_chk_sum;
                end
            end
            if (r_state == S_CHK && w_next == S_ERROR) begin
                r_err <= 1'b1;
            end else if (r_state == S_ERROR && w_accept && w_is_sync) begin
                r_err <= 1'b0;
            end
        end
    end
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // RAM: the loader owns the write port outside RUN, the CPU inside RUN.
    // Writes are suppressed while reset is asserted so that a reset arriving
    // mid-load cannot commit one more byte.
    // ------------------------------------------------------------------------
    assign w_mem_we    = ~reset & (w_ld_we | ((r_state == S_RUN) & cpu_we));
    assign w_mem_addr  = w_ld_we ? r_ptr   : cpu_addr;
    assign w_mem_wdata = w_ld_we ? rx_data : cpu_wdata;

    always_ff @(posedge clk_qzt) begin
        if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
    end

    assign rx_ready     = w_rx_ready;
    assign cpu_en       = w_cpu_en;
    assign cpu_reset    = w_cpu_reset;
    assign busy         = w_busy;
    assign load_done    = r_load_done;
    assign cpu_rdata    = r_cpu_rdata;
    // The CPU loads PC = res_addr + 1, so point one below the start address.
    assign cpu_res_addr = r_start - 8'd1;

endmodule
`default_nettype wire
